// File: rtl/dlyseq_pkg.sv
// rtl/dlyseq_pkg.sv - shared FSM state type and error codes for the delay chain sequencer
// Contents:
//   state_e        sequencer FSM states
//   ERR_*          codes reported on the error port
package dlyseq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT   = 2'd1;
  localparam logic [1:0] ERR_NOT_QUIET = 2'd2;

endpackage

// File: rtl/dlyseq_sync2.sv
// rtl/dlyseq_sync2.sv - two-flop synchronizer with synchronous active-high reset
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset, clears both stages
//   d      in   asynchronous input
//   q      out  synchronized output (second stage)
module dlyseq_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/delay_chain_sequencer.sv
// rtl/delay_chain_sequencer.sv - toggles an external delay chain and measures round-trip delay
// Optional feature: define DLYSEQ_STATS_EN to build min/max delay statistics registers.
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   start       in   one-cycle pulse, accepted only when idle
//   num_iters   in   transitions to launch, latched on accepted start
//   chain_in    out  registered drive into the chain
//   chain_out   in   asynchronous chain output
//   busy        out  high from accepted start until done
//   done        out  one-cycle pulse at end of run
//   error       out  0 ok, 1 timeout, 2 not quiescent at start
//   last_delay  out  delay of the most recent completed transition
//   iter_count  out  completed transitions in the current/last run
//   min_delay   out  smallest delay of the run (0 when statistics are not built)
//   max_delay   out  largest delay of the run (0 when statistics are not built)
module delay_chain_sequencer
  import dlyseq_pkg::*;
#(
  parameter int   CNT_W   = 16,
  parameter int   ITER_W  = 8,
  parameter logic INVERT  = 1'b1,
  parameter int   TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ITER_W-1:0] num_iters,
  output logic              chain_in,
  input  logic              chain_out,
  output logic              busy,
  output logic              done,
  output logic [1:0]        error,
  output logic [CNT_W-1:0]  last_delay,
  output logic [ITER_W-1:0] iter_count,
  output logic [CNT_W-1:0]  min_delay,
  output logic [CNT_W-1:0]  max_delay
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e            state_q, state_d;
  logic              chain_in_q, chain_in_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        error_q, error_d;
  logic [CNT_W-1:0]  last_q, last_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [ITER_W-1:0] niters_q, niters_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef DLYSEQ_STATS_EN
  logic [CNT_W-1:0]  min_q, min_d;
  logic [CNT_W-1:0]  max_q, max_d;
`endif

  logic              s2;
  logic              settled;
  logic [ITER_W-1:0] iter_inc;
  logic [CNT_W-1:0]  cnt_inc;

  dlyseq_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (chain_out),
    .q     (s2)
  );

  // Chain output has reached the polarity implied by the current drive.
  assign settled  = (s2 == (chain_in_q ^ INVERT));
  assign iter_inc = iter_q + 1'b1;
  // Saturating increment; the counter never wraps back to small values.
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      chain_in_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= ERR_NONE;
      last_q     <= '0;
      iter_q     <= '0;
      niters_q   <= '0;
      cnt_q      <= '0;
`ifdef DLYSEQ_STATS_EN
      min_q      <= '0;
      max_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      chain_in_q <= chain_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      last_q     <= last_d;
      iter_q     <= iter_d;
      niters_q   <= niters_d;
      cnt_q      <= cnt_d;
`ifdef DLYSEQ_STATS_EN
      min_q      <= min_d;
      max_q      <= max_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    chain_in_d = chain_in_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    last_d     = last_q;
    iter_d     = iter_q;
    niters_d   = niters_q;
    cnt_d      = cnt_q;
`ifdef DLYSEQ_STATS_EN
    min_d      = min_q;
    max_d      = max_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          niters_d = num_iters;
          iter_d   = '0;
          error_d  = ERR_NONE;
          last_d   = '0;
          busy_d   = 1'b1;
          state_d  = CHECK;
`ifdef DLYSEQ_STATS_EN
          // All-ones/zero seed makes the first match load both registers.
          min_d    = '1;
          max_d    = '0;
`endif
        end
      end

      CHECK: begin
        if (niters_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else if (!settled) begin
          error_d = ERR_NOT_QUIET;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          chain_in_d = ~chain_in_q;
          cnt_d      = '0;
          state_d    = WAIT;
        end
      end

      WAIT: begin
        cnt_d = cnt_inc;
        // Match is tested first so it wins when it coincides with the timeout.
        if (settled) begin
          last_d = cnt_q;
          iter_d = iter_inc;
`ifdef DLYSEQ_STATS_EN
          if (cnt_q < min_q) min_d = cnt_q;
          if (cnt_q > max_q) max_d = cnt_q;
`endif
          if (iter_inc == niters_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            // Next launch goes out on this same edge.
            chain_in_d = ~chain_in_q;
            cnt_d      = '0;
          end
        end else if (cnt_q >= TIMEOUT_C) begin
          error_d = ERR_TIMEOUT;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign chain_in   = chain_in_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign last_delay = last_q;
  assign iter_count = iter_q;
`ifdef DLYSEQ_STATS_EN
  assign min_delay  = min_q;
  assign max_delay  = max_q;
`else
  assign min_delay  = '0;
  assign max_delay  = '0;
`endif

endmodule

// File: doc/delay_chain_sequencer.md
Name: delay_chain_sequencer

Overview:
- Clocked controller that exercises an external delay/inverter chain, typically a prsim-simulated netlist bridged through the VPI co-simulation layer.
- Toggles the chain input, waits for the chain output to settle to its expected polarity, and measures the round-trip delay in clock cycles.
- Repeats this for a programmed number of iterations.
- Reports the last delay and, optionally, min/max statistics, with timeout and quiescence error detection.

Parameters:
- CNT_W, 16, width of delay counters and delay result ports.
- ITER_W, 8, width of iteration count.
- INVERT, 1, 1 if the chain has an odd number of inverting stages (expected out = in ^ INVERT).
- TIMEOUT, 1000, max cycles waited per transition before error; must be < 2^CNT_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run when idle.
- num_iters  in  ITER_W  transitions to launch; sampled on accepted start.
- chain_in  out  1  registered drive into the chain.
- chain_out  in  1  asynchronous chain output.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of run.
- error  out  2  0 ok, 1 timeout, 2 not quiescent at start; held until next accepted start.
- last_delay  out  CNT_W  delay of the most recent completed transition.
- iter_count  out  ITER_W  completed transitions in the current/last run.
- min_delay  out  CNT_W  statistics, see Optional Feature.
- max_delay  out  CNT_W  statistics, see Optional Feature.

Behaviour:
- Synchronizer: chain_out passes through a 2-flop synchronizer (s1, s2) before any use. Reset clears both flops.
- Reset: all outputs are 0, chain_in=0, state IDLE. Reset mid-run aborts immediately with no done pulse. chain_in returns to 0 on the same edge.
- FSM states: IDLE, CHECK, WAIT, DONE.
- IDLE:
  - start=1 accepts; start during busy is ignored.
  - On accept, latch num_iters, clear iter_count, error and last_delay, set busy, go to CHECK.
- CHECK (one cycle):
  - If num_iters latched = 0: go to DONE with error=0 and no toggle.
  - Else if s2 != chain_in ^ INVERT: error=2, go to DONE.
  - Else toggle chain_in, clear delay counter, go to WAIT.
- WAIT:
  - Counter increments on every edge.
  - Match: on the first edge where the counter value is k and s2 == chain_in ^ INVERT, set last_delay = k.
  - Ideal loopback (chain_out tied to chain_in with INVERT=0) yields k=2.
  - On match, iter_count++. If iter_count reaches latched num_iters, go to DONE. Otherwise toggle chain_in, clear the counter and stay in WAIT; back-to-back launches have no idle cycle.
  - Timeout: if the counter reaches TIMEOUT without a match, error=1 and go to DONE. chain_in holds its value. last_delay is unchanged.
  - If match and timeout coincide on the same edge, match wins.
- DONE: done=1 for one cycle, busy drops on the same edge, return to IDLE.
- chain_in retains its final value across runs; polarity alternates with parity of the total launches.
- Counter saturates at 2^CNT_W-1; it never wraps.

Optional Feature:
- DLYSEQ_STATS_EN defined:
  - min_delay/max_delay are updated on every match.
  - On accepted start they initialise to all-ones/zero respectively.
  - On the first match of a run, both take that delay.
  - A run ending with error retains the stats gathered so far.
- Not defined: min_delay and max_delay are tied to 0 and no stats registers exist.

Decomposition:
- Package dlyseq_pkg holds:
  - the FSM state enum (IDLE, CHECK, WAIT, DONE);
  - error code constants ERR_NONE=0, ERR_TIMEOUT=1, ERR_NOT_QUIET=2.
- One sub-module, dlyseq_sync2: the 2-flop synchronizer with synchronous reset. Everything else is in the top module.

Test Plan:
- Loopback, INVERT=0, num_iters=4, start -> chain_in toggles 4 times; last_delay=2 each transition; iter_count=4; done pulses once; error=0; min=max=2 with stats.
- Loopback through a 5-cycle delay model, INVERT=1 (inverted loopback), num_iters=3 -> last_delay=7; error=0; total busy duration = 1+3×7+1 cycles, ±1 per spec edge.
- chain_out stuck at 0, INVERT=0, TIMEOUT=20, num_iters=2 -> error=1 after 20 WAIT cycles; iter_count=0; done pulses; chain_in=1 held.
- Chain not quiescent: chain_out=1, chain_in=0, INVERT=0, start -> error=2 after CHECK; no chain_in toggle; done pulses.
- num_iters=0 -> done within 3 cycles of start; no toggle; error=0. Then start during busy of a 5-iteration run -> ignored; iter_count=5.
- Reset asserted in WAIT of iteration 2 of 4 -> next edge: all outputs 0, chain_in=0, no done pulse. Following start runs cleanly.
